// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and forwarding control for a 5-stage RV32I pipeline.
// Tracks destination registers of in-flight instructions in a three-slot scoreboard
// (EX, MEM, WB). From this it produces registered forwarding selects for the execute
// stage, and combinational stall, flush and freeze strobes for the pipeline registers.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   id_rs1/id_rs2             source registers of the ID instruction
//   id_use_rs1/id_use_rs2     ID instruction really reads rs1/rs2
//   id_WReg/id_RegWrite/id_is_load  destination info of the ID instruction
//   branch_PC_contral         taken redirect from execute
//   dmem_busy                 data memory not ready, freeze everything
//   keep_front/flush_ifid/nop_idex/keep_back  pipeline register control
//   forwarding_*_pyc          execute forwarding selects, bit1 = rs1, bit0 = rs2
//   stall_count/flush_count   wrapping performance counters
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_WReg,
  input  logic             id_RegWrite,
  input  logic             id_is_load,
  input  logic             branch_PC_contral,
  input  logic             dmem_busy,
  output logic             keep_front,
  output logic             flush_ifid,
  output logic             nop_idex,
  output logic             keep_back,
  output logic [1:0]       forwarding_ID_EX_pyc,
  output logic [1:0]       forwarding_ID_MEM_pyc,
  output logic [1:0]       forwarding_stall_load_pyc,
  output logic [1:0]       forwarding_ID_MEM_hazard_pyc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {StRun, StLstall, StFreeze} state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  localparam logic [1:0] LdCnt = 2'(LOAD_LAT - 1);

  slot_t            r_ex, r_mem, r_wb;
  state_e           r_state, r_saved;
  logic [1:0]       r_cnt;
  logic [1:0]       r_fwd_ex, r_fwd_mem, r_fwd_sl, r_fwd_hz;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  state_e     w_cur, w_state_nxt, w_saved_nxt;
  logic [1:0] w_cnt_nxt;
  logic       w_keep_front, w_flush, w_nop, w_keep_back;
  logic       w_load_use;
  logic [3:0] w_sel1, w_sel2;

  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.v & s.we & (s.rd == rs) & (s.rd != 5'd0);
  endfunction

  // Returns {ID_EX, ID_MEM, stall_load, ID_MEM_hazard}; at most one bit set.
  function automatic logic [3:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    logic [3:0] sel;
    sel = 4'b0000;
    if (use_rs) begin
      if (hit(ex, rs) && !ex.ld)        sel = 4'b1000;
      else if (hit(mem, rs) && !mem.ld) sel = 4'b0100;
      else if (hit(mem, rs))            sel = 4'b0010;
      else if (hit(wb, rs))             sel = 4'b0001;
    end
    return sel;
  endfunction

  assign w_sel1 = fwd_sel(id_use_rs1, id_rs1, r_ex, r_mem, r_wb);
  assign w_sel2 = fwd_sel(id_use_rs2, id_rs2, r_ex, r_mem, r_wb);

  assign w_load_use = r_ex.ld & ((id_use_rs1 & hit(r_ex, id_rs1)) |
                                 (id_use_rs2 & hit(r_ex, id_rs2)));

  always_comb begin
    w_keep_front = 1'b0;
    w_flush      = 1'b0;
    w_nop        = 1'b0;
    w_keep_back  = 1'b0;
    // On leaving FREEZE the saved state acts in the same cycle, so no dead cycle.
    w_cur        = (r_state == StFreeze) ? r_saved : r_state;
    w_state_nxt  = w_cur;
    w_saved_nxt  = r_saved;
    w_cnt_nxt    = r_cnt;
    if (dmem_busy) begin
      w_keep_front = 1'b1;
      w_keep_back  = 1'b1;
      w_state_nxt  = StFreeze;
      w_saved_nxt  = w_cur;
    end else if (branch_PC_contral) begin
      // Redirect wins over any pending load-use bubble.
      w_flush     = 1'b1;
      w_nop       = 1'b1;
      w_state_nxt = StRun;
      w_cnt_nxt   = 2'd0;
    end else if (w_cur == StLstall && r_cnt != 2'd0) begin
      w_keep_front = 1'b1;
      w_nop        = 1'b1;
      w_cnt_nxt    = r_cnt - 2'd1;
    end else if (w_load_use) begin
      w_keep_front = 1'b1;
      w_nop        = 1'b1;
      w_state_nxt  = StLstall;
      w_cnt_nxt    = LdCnt;
    end else begin
      w_state_nxt = StRun;
    end
  end

  // Strobes read as zero while reset is held, whatever the inputs do.
  assign keep_front = rst & w_keep_front;
  assign flush_ifid = rst & w_flush;
  assign nop_idex   = rst & w_nop;
  assign keep_back  = rst & w_keep_back;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= StRun;
      r_saved     <= StRun;
      r_cnt       <= 2'd0;
      r_fwd_ex    <= 2'b00;
      r_fwd_mem   <= 2'b00;
      r_fwd_sl    <= 2'b00;
      r_fwd_hz    <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!dmem_busy) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= w_nop ? '0 : {1'b1, id_WReg, id_RegWrite, id_is_load};
        if (w_nop) begin
          r_fwd_ex  <= 2'b00;
          r_fwd_mem <= 2'b00;
          r_fwd_sl  <= 2'b00;
          r_fwd_hz  <= 2'b00;
        end else begin
          r_fwd_ex  <= {w_sel1[3], w_sel2[3]};
          r_fwd_mem <= {w_sel1[2], w_sel2[2]};
          r_fwd_sl  <= {w_sel1[1], w_sel2[1]};
          r_fwd_hz  <= {w_sel1[0], w_sel2[0]};
        end
        r_stall_cnt <= r_stall_cnt + CNT_W'(w_keep_front);
        r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush);
      end
    end
  end

  assign forwarding_ID_EX_pyc         = r_fwd_ex;
  assign forwarding_ID_MEM_pyc        = r_fwd_mem;
  assign forwarding_stall_load_pyc    = r_fwd_sl;
  assign forwarding_ID_MEM_hazard_pyc = r_fwd_hz;
  assign stall_count                  = r_stall_cnt;
  assign flush_count                  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: LOAD_LAT=1 instance driven through a scripted
// instruction stream with expected forwarding selects queued per cycle, plus a
// LOAD_LAT=2 instance for the longer load-use penalty.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  id_rs1, id_rs2, id_WReg;
  logic        id_use_rs1, id_use_rs2, id_RegWrite, id_is_load;
  logic        branch_PC_contral, dmem_busy;
  logic        keep_front, flush_ifid, nop_idex, keep_back;
  logic [1:0]  fwd_ex, fwd_mem, fwd_sl, fwd_hz;
  logic [31:0] stall_count, flush_count;

  logic [4:0]  b_rs1, b_rs2, b_WReg;
  logic        b_use1, b_use2, b_we, b_ld;
  logic        b_kf, b_fl, b_nop, b_kb;
  logic [1:0]  b_ex, b_mem, b_sl, b_hz;
  logic [31:0] b_stall, b_flush;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_dut (
    .clk                          (clk),
    .rst                          (rst),
    .id_rs1                       (id_rs1),
    .id_rs2                       (id_rs2),
    .id_use_rs1                   (id_use_rs1),
    .id_use_rs2                   (id_use_rs2),
    .id_WReg                      (id_WReg),
    .id_RegWrite                  (id_RegWrite),
    .id_is_load                   (id_is_load),
    .branch_PC_contral            (branch_PC_contral),
    .dmem_busy                    (dmem_busy),
    .keep_front                   (keep_front),
    .flush_ifid                   (flush_ifid),
    .nop_idex                     (nop_idex),
    .keep_back                    (keep_back),
    .forwarding_ID_EX_pyc         (fwd_ex),
    .forwarding_ID_MEM_pyc        (fwd_mem),
    .forwarding_stall_load_pyc    (fwd_sl),
    .forwarding_ID_MEM_hazard_pyc (fwd_hz),
    .stall_count                  (stall_count),
    .flush_count                  (flush_count)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(32)) u_dut_lat2 (
    .clk                          (clk),
    .rst                          (rst),
    .id_rs1                       (b_rs1),
    .id_rs2                       (b_rs2),
    .id_use_rs1                   (b_use1),
    .id_use_rs2                   (b_use2),
    .id_WReg                      (b_WReg),
    .id_RegWrite                  (b_we),
    .id_is_load                   (b_ld),
    .branch_PC_contral            (1'b0),
    .dmem_busy                    (1'b0),
    .keep_front                   (b_kf),
    .flush_ifid                   (b_fl),
    .nop_idex                     (b_nop),
    .keep_back                    (b_kb),
    .forwarding_ID_EX_pyc         (b_ex),
    .forwarding_ID_MEM_pyc        (b_mem),
    .forwarding_stall_load_pyc    (b_sl),
    .forwarding_ID_MEM_hazard_pyc (b_hz),
    .stall_count                  (b_stall),
    .flush_count                  (b_flush)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // Control nibble order: {keep_front, flush_ifid, nop_idex, keep_back}.
  localparam logic [3:0] CtlNone   = 4'b0000;
  localparam logic [3:0] CtlStall  = 4'b1010;
  localparam logic [3:0] CtlFlush  = 4'b0110;
  localparam logic [3:0] CtlFreeze = 4'b1001;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {ID_EX, ID_MEM, stall_load, ID_MEM_hazard}, two bits each.
  function automatic logic [7:0] pyc();
    return {fwd_ex, fwd_mem, fwd_sl, fwd_hz};
  endfunction

  task automatic id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                    input logic u2, input logic [4:0] wd, input logic we, input logic ld);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_WReg = wd; id_RegWrite = we; id_is_load = ld;
  endtask

  // One pipeline cycle: check strobes mid-cycle, queue the selects expected after the edge.
  task automatic cyc(input string tag, input logic br, input logic busy,
                     input logic [3:0] exp_ctl, input logic [7:0] exp_pyc);
    logic [7:0] e;
    branch_PC_contral = br;
    dmem_busy         = busy;
    #2;
    chk({tag, " ctl"}, {keep_front, flush_ifid, nop_idex, keep_back}, exp_ctl);
    exp_q.push_back(exp_pyc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " pyc"}, pyc(), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    branch_PC_contral = 1'b0;
    dmem_busy = 1'b0;
    b_rs1 = 5'd0; b_rs2 = 5'd0; b_use1 = 1'b0; b_use2 = 1'b0;
    b_WReg = 5'd0; b_we = 1'b0; b_ld = 1'b0;

    #12;
    chk("reset ctl", {keep_front, flush_ifid, nop_idex, keep_back}, 4'b0000);
    chk("reset pyc", pyc(), 8'h00);
    chk("reset cnt", {stall_count, flush_count}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priorities.
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  cyc("add x5", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  cyc("ex fwd", 1'b0, 1'b0, CtlNone, 8'h80);
    id(5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  cyc("mem fwd", 1'b0, 1'b0, CtlNone, 8'h10);
    id(5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); cyc("wb+mem", 1'b0, 1'b0, CtlNone, 8'h12);
    id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);  cyc("x0 wr", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); cyc("x0 rd", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd11, 5'd11, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); cyc("unused rs1", 1'b0, 1'b0, CtlNone, 8'h40);
    chk("no stall yet", stall_count, 32'd0);

    // Load-use, one bubble, consumer picks up the load result from MEM.
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);  cyc("lw x7", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  cyc("lu stall", 1'b0, 1'b0, CtlStall, 8'h00);
    cyc("lu issue", 1'b0, 1'b0, CtlNone, 8'h0C);
    chk("stall cnt 1", stall_count, 32'd1);

    // Load-use coinciding with a redirect: flush wins.
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1); cyc("lw x12", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd12, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0); cyc("flush", 1'b1, 1'b0, CtlFlush, 8'h00);
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("post flush", 1'b0, 1'b0, CtlNone, 8'h00);
    chk("flush cnt", flush_count, 32'd1);
    chk("stall cnt after flush", stall_count, 32'd1);

    // Freeze in LSTALL, with a redirect attempt that must be ignored while frozen.
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1); cyc("lw x14", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd14, 5'd1, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0); cyc("lu2 stall", 1'b0, 1'b0, CtlStall, 8'h00);
    cyc("frz1", 1'b0, 1'b1, CtlFreeze, 8'h00);
    cyc("frz2", 1'b1, 1'b1, CtlFreeze, 8'h00);
    cyc("frz3", 1'b0, 1'b1, CtlFreeze, 8'h00);
    chk("frz cnt", {stall_count, flush_count}, {32'd2, 32'd1});
    cyc("lu2 issue", 1'b0, 1'b0, CtlNone, 8'h08);

    // Freeze in RUN holds nonzero selects and the scoreboard.
    id(5'd15, 5'd15, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0); cyc("frz run", 1'b0, 1'b1, CtlFreeze, 8'h08);
    cyc("after frz", 1'b0, 1'b0, CtlNone, 8'hC0);
    chk("cnt after frz", {stall_count, flush_count}, {32'd2, 32'd1});

    // Reset pulsed while a load-use stall is active.
    id(5'd16, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b1); cyc("lw x17", 1'b0, 1'b0, CtlNone, 8'h80);
    id(5'd17, 5'd0, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);
    #2;
    chk("pre rst ctl", {keep_front, flush_ifid, nop_idex, keep_back}, CtlStall);
    rst = 1'b0;
    #1;
    chk("rst ctl", {keep_front, flush_ifid, nop_idex, keep_back}, CtlNone);
    chk("rst pyc", pyc(), 8'h00);
    chk("rst cnt", {stall_count, flush_count}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("rst resume", 1'b0, 1'b0, CtlNone, 8'h00);
    id(5'd18, 5'd0, 1'b1, 1'b1, 5'd19, 1'b1, 1'b0); cyc("post rst fwd", 1'b0, 1'b0, CtlNone, 8'h80);
    chk("post rst stall", stall_count, 32'd0);

    // LOAD_LAT=2: two bubbles, consumer forwards from WB.
    b_rs1 = 5'd1; b_use1 = 1'b1; b_WReg = 5'd7; b_we = 1'b1; b_ld = 1'b1;
    @(posedge clk);
    #1;
    b_rs1 = 5'd7; b_rs2 = 5'd7; b_use2 = 1'b1; b_WReg = 5'd8; b_ld = 1'b0;
    #2;
    chk("lat2 s1", {b_kf, b_nop}, 2'b11);
    @(posedge clk);
    #1;
    #2;
    chk("lat2 s2", {b_kf, b_nop}, 2'b11);
    chk("lat2 s2 pyc", {b_ex, b_mem, b_sl, b_hz}, 8'h00);
    @(posedge clk);
    #1;
    #2;
    chk("lat2 go", {b_kf, b_nop}, 2'b00);
    @(posedge clk);
    #1;
    chk("lat2 pyc", {b_ex, b_mem, b_sl, b_hz}, 8'h03);
    chk("lat2 stall", b_stall, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
